// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio peak-detection blocks.
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int FRAME_N  = 100;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } minmax_state_e;

endpackage

// File: rtl/audio_minmax_if.sv
// Frame request/result bundle between the capture buffer and the peak detector.
interface audio_minmax_if
  import audio_pkg::*;
#(
  parameter int N = FRAME_N,
  parameter int W = SAMPLE_W
);

  logic                start;
  logic signed [W-1:0] raw_audio [N-1:0];
  logic                d;
  logic signed [W-1:0] out_max;
  logic signed [W-1:0] out_min;

  modport master (
    output start,
    output raw_audio,
    input  d,
    input  out_max,
    input  out_min
  );

  modport slave (
    input  start,
    input  raw_audio,
    output d,
    output out_max,
    output out_min
  );

endinterface

// File: rtl/minmax_update.sv
// Combinational signed max/min step; shared with the streaming peak detector.
module minmax_update #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] cur_max,
  input  logic signed [W-1:0] cur_min,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] nxt_max,
  output logic signed [W-1:0] nxt_min
);

  // Ties keep the current value.
  always_comb begin
    nxt_max = (sample > cur_max) ? sample : cur_max;
    nxt_min = (sample < cur_min) ? sample : cur_min;
  end

endmodule

// File: rtl/audio_minmax.sv
// Scans one N-sample signed frame, one sample per clock, and reports its max/min.
module audio_minmax
  import audio_pkg::*;
#(
  parameter int N = FRAME_N,
  parameter int W = SAMPLE_W
) (
  input  logic           clk,
  input  logic           reset,
  audio_minmax_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  minmax_state_e       state;
  logic [IW-1:0]       idx;
  logic                done_r;
  logic signed [W-1:0] max_r;
  logic signed [W-1:0] min_r;
  logic signed [W-1:0] cur_sample;
  logic signed [W-1:0] nxt_max;
  logic signed [W-1:0] nxt_min;

  always_comb begin
    cur_sample = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IW'(i)) cur_sample = bus.raw_audio[i];
    end
  end

  minmax_update #(.W(W)) u_update (
    .cur_max (max_r),
    .cur_min (min_r),
    .sample  (cur_sample),
    .nxt_max (nxt_max),
    .nxt_min (nxt_min)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      done_r <= 1'b0;
      max_r  <= '0;
      min_r  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            max_r  <= bus.raw_audio[0];
            min_r  <= bus.raw_audio[0];
            idx    <= IW'(1);
            // A one-sample frame is complete as soon as it is loaded.
            done_r <= (N == 1);
            state  <= (N == 1) ? DONE : SCAN;
          end
        end
        SCAN: begin
          max_r <= nxt_max;
          min_r <= nxt_min;
          idx   <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d       = done_r;
  assign bus.out_max = max_r;
  assign bus.out_min = min_r;

endmodule

// File: tb/tb_audio_minmax.sv
// Randomized and directed frames checked against a plain max/min reference.
module tb_audio_minmax;
  import audio_pkg::*;

  localparam int N = FRAME_N;
  localparam int W = SAMPLE_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_minmax_if #(.N(N), .W(W)) bus ();

  audio_minmax #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] frame [N];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_peaks(output longint mx, output longint mn);
    mx = frame[0];
    mn = frame[0];
    for (int i = 1; i < N; i++) begin
      if (longint'(frame[i]) > mx) mx = frame[i];
      if (longint'(frame[i]) < mn) mn = frame[i];
    end
  endfunction

  task automatic load_frame();
    for (int i = 0; i < N; i++) bus.raw_audio[i] = frame[i];
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // dup_at >= 0 re-asserts start that many cycles into the scan.
  task automatic run_frame(input string tag, input int dup_at);
    longint mx, mn;
    int cycles;
    load_frame();
    ref_peaks(mx, mn);
    pulse_start();
    check({tag, "_d_clr"}, longint'(bus.d), 0);
    cycles = 0;
    while (!bus.d && cycles < 4 * N) begin
      if (cycles == dup_at) bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, cycles, N - 1);
    check({tag, "_max"}, longint'(bus.out_max), mx);
    check({tag, "_min"}, longint'(bus.out_min), mn);
  endtask

  task automatic fill_random(input bit narrow);
    for (int i = 0; i < N; i++)
      frame[i] = narrow ? W'($urandom_range(0, 20)) - W'(10) : W'($urandom);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = '0;
    load_frame();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d", longint'(bus.d), 0);
    check("rst_max", longint'(bus.out_max), 0);
    check("rst_min", longint'(bus.out_min), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_frame("zeros", -1);

    for (int i = 0; i < N; i++) frame[i] = W'(i - 50);
    run_frame("ramp", -1);

    frame[0] = 1000; frame[N-1] = -1000;
    run_frame("edge_a", -1);
    frame[0] = -1000; frame[N-1] = 1000;
    run_frame("edge_b", -1);

    for (int i = 0; i < N; i++) frame[i] = 5;
    frame[17] = 32'sh7FFFFFFF;
    frame[83] = 32'sh80000000;
    run_frame("full", -1);
    check("full_max_lit", longint'(bus.out_max), 64'sd2147483647);
    check("full_min_lit", longint'(bus.out_min), -64'sd2147483648);

    for (int i = 0; i < N; i++) frame[i] = -7;
    run_frame("restart", -1);

    fill_random(1'b0);
    load_frame();
    pulse_start();
    repeat (39) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_d", longint'(bus.d), 0);
    check("midrst_max", longint'(bus.out_max), 0);
    check("midrst_min", longint'(bus.out_min), 0);
    repeat (N + 5) @(posedge clk);
    #1;
    check("midrst_idle_d", longint'(bus.d), 0);
    run_frame("post_rst", -1);

    fill_random(1'b1);
    run_frame("dup_start", 20);

    for (int k = 0; k < 8; k++) begin
      fill_random(k[0]);
      run_frame($sformatf("rand%0d", k), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_minmax.md
# audio_minmax

Sequential peak detector for one frame of signed PCM audio. It scans a parallel array of `N` samples, one per clock, after a `start` pulse, and reports the signed maximum and minimum of the frame. It raises a sticky done flag when the scan finishes. It sits between the sample-capture buffer and the normalisation/gain stage, which consumes `out_max` and `out_min` once `d` is high.

## Interface
- `N` — default 100 — number of samples per frame; must be ≥ 1.
- `W` — default 32 — sample width in bits; samples are two's-complement signed.
- `clk`  in  1  — single system clock; all logic updates on its rising edge.
- `reset`  in  1  — reset is synchronous and active-high; it clears all state.
- `start`  in  1  — single-cycle request to begin a scan; sampled only in IDLE or DONE.
- `raw_audio`  in  N × W signed (unpacked array `[N-1:0]`)  — frame samples. The driver holds them stable from the `start` cycle until `d` rises.
- `d`  out  1  — done flag; high means `out_max`/`out_min` are valid for the last frame.
- `out_max`  out  W signed  — maximum sample of the last completed frame.
- `out_min`  out  W signed  — minimum sample of the last completed frame.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **Reset** (synchronous, `reset`=1 at an edge):
  - state goes to IDLE; `d`=0, `out_max`=0, `out_min`=0.
  - the index counter resets to 0.
  - reset has priority over `start` and over an in-progress scan; a partial scan is discarded.
- **IDLE or DONE, with `start`=1:**
  - running max and min are loaded with `raw_audio[0]`; index is set to 1; `d` is cleared to 0.
  - next state is SCAN. If `N`==1, next state is DONE directly, with `d`=1.
- **SCAN, each cycle:**
  - reads `raw_audio[idx]`.
  - updates max if the sample is greater (signed compare); updates min if it is less.
  - increments idx.
  - when idx==N-1 is processed, next state is DONE with `d`=1.
- **DONE:**
  - `d` stays high; the outputs hold.
  - `start` launches a new scan as described above.
- **`start` during SCAN:** ignored; the scan is not restarted.
- **`out_max`/`out_min`:** these are the running registers themselves. They are valid only while `d`=1; their values during SCAN are undefined to consumers.
- **Arithmetic:**
  - all comparisons are signed `W`-bit; no widening or saturation is needed.
  - equal values leave the registers unchanged.
- **Index counter width:** clog2(N), minimum 1 bit.

## Timing
- Let the `start` edge be edge 0. Edges 1 … N-1 process samples 1 … N-1.
- `d` is high after edge N-1, i.e. N-1 cycles of latency; this is 99 cycles for N=100.
- For `N`==1, `d` is high after edge 0.
- `d` is a level, not a pulse. It falls on the edge that accepts the next `start`, or on reset.
- There are no combinational paths from inputs to outputs; all outputs are registered.
- Throughput is one frame per N clocks, plus 0 idle cycles when `start` is asserted in DONE.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W`=32
  - default `FRAME_N`=100
  - the `sample_t` signed typedef
  - the FSM state enum `minmax_state_e` {IDLE, SCAN, DONE}
- Sub-module `minmax_update`, purely combinational:
  - inputs: current max, current min, and the sample.
  - outputs: next max and next min.
  - it contains the signed compare logic and is reused by the streaming variant.
- The top level holds the FSM, index counter, sample multiplexer (`raw_audio[idx]`) and the output registers.

## Test plan
- **All zeros**, N=100: reset for 1 cycle, pulse `start` → `d` rises exactly 99 cycles after the start edge; `out_max`=0 and `out_min`=0.
- **Mixed-sign ramp**, `raw_audio[i]`=i-50: → `out_max`=49, `out_min`=-50. Also place the extremes at index 0 and at index 99 to check the first and last boundaries.
- **Full-range extremes**: `raw_audio[17]`=32'sh7FFFFFFF, `raw_audio[83]`=32'sh80000000, others 5 → `out_max`=2147483647, `out_min`=-2147483648. This confirms the compare is signed.
- **Restart from DONE**: after frame A completes, load frame B (all -7) and pulse `start` → `d` drops on the start edge and rises 99 cycles later; `out_max`=`out_min`=-7.
- **Reset mid-scan**: assert `reset` 40 cycles after `start` → next edge gives `d`=0 and outputs 0, state IDLE. A later `start` produces correct results.
- **Start during SCAN** is ignored: pulse `start` again at cycle 20 → `d` still rises at cycle 99, with results from the original frame.
